// File: rtl/sync_read_2_write_gray.sv
// Read-pointer synchronizer for the write side of an async FIFO.
// Brings the Gray read pointer into clock_write through SYNC_STAGES flops,
// converts it to binary, and derives full / free-slot count and read progress.
// Optional Gray-violation checker: define SYNC_GRAY_CHECK_EN.
module sync_read_2_write_gray #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock_write,
  input  logic                  write_reset_n,
  input  logic [ADDR_WIDTH:0]   read_pointer_gray,
  input  logic [ADDR_WIDTH:0]   write_pointer_bin,
  output logic [ADDR_WIDTH:0]   sync_read_pointer,
  output logic [ADDR_WIDTH:0]   sync_read_pointer_bin,
  output logic                  read_advance,
  output logic [ADDR_WIDTH:0]   advance_delta,
  output logic [ADDR_WIDTH:0]   free_slots,
  output logic                  full,
  output logic                  gray_error
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LAST  = SYNC_STAGES - 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  // Reject synchronizer depths outside the supported range at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_read_2_write_gray: SYNC_STAGES must be in 2..4");
  end

  logic [PTR_W-1:0] stage_q [SYNC_STAGES];
  logic [PTR_W-1:0] stage_d [SYNC_STAGES];
  logic [PTR_W-1:0] bin_q, bin_d;
  logic [PTR_W-1:0] delta_q, delta_d;
  logic             adv_q, adv_d;
  logic [PTR_W-1:0] gray_bin_c;
  logic [PTR_W-1:0] occ_c;

  // Synchronizer shift chain.
  always_comb begin
    for (int i = 0; i < int'(SYNC_STAGES); i++) stage_d[i] = '0;
    stage_d[0] = read_pointer_gray;
    for (int i = 1; i < int'(SYNC_STAGES); i++) stage_d[i] = stage_q[i-1];
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    gray_bin_c = '0;
    for (int i = 0; i < int'(PTR_W); i++) gray_bin_c[i] = ^(stage_q[LAST] >> i);
  end

  // Next binary pointer and the progress it represents.
  always_comb begin
    bin_d   = gray_bin_c;
    delta_d = gray_bin_c - bin_q;
    adv_d   = (delta_d != '0);
  end

  // Pipeline registers.
  always_ff @(posedge clock_write or negedge write_reset_n) begin
    if (!write_reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      adv_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_d[i];
      bin_q   <= bin_d;
      delta_q <= delta_d;
      adv_q   <= adv_d;
    end
  end

  // Occupancy against the local write pointer; combinational so full tracks writes immediately.
  always_comb begin
    occ_c      = write_pointer_bin - bin_q;
    free_slots = DEPTH_P - occ_c;
    full       = (occ_c == DEPTH_P);
  end

  assign sync_read_pointer     = stage_q[LAST];
  assign sync_read_pointer_bin = bin_q;
  assign read_advance          = adv_q;
  assign advance_delta         = delta_q;

`ifdef SYNC_GRAY_CHECK_EN
  logic gray_err_q, gray_err_d;

  // Sticky flag: the last two stages may differ in at most one bit.
  always_comb begin
    gray_err_d = gray_err_q;
    if ($countones(stage_q[LAST] ^ stage_q[LAST-1]) > 1) gray_err_d = 1'b1;
  end

  // Gray-error register.
  always_ff @(posedge clock_write or negedge write_reset_n) begin
    if (!write_reset_n) gray_err_q <= 1'b0;
    else                gray_err_q <= gray_err_d;
  end

  assign gray_error = gray_err_q;
`else
  assign gray_error = 1'b0;
`endif

endmodule

// File: tb/tb_sync_read_2_write_gray.sv
// Bench for sync_read_2_write_gray (ADDR_WIDTH=3, SYNC_STAGES=2).
// Edge-history model checked every cycle, plus directed literal checks.
module tb_sync_read_2_write_gray;

  localparam int S     = 2;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] rp, wp;
  logic [3:0] sync_rp, sync_bin, delta, free_slots;
  logic       adv, full, gray_error;

  int n_cmp = 0;
  int n_bad = 0;

  sync_read_2_write_gray #(.ADDR_WIDTH(3), .SYNC_STAGES(S)) dut (
    .clock_write           (clk),
    .write_reset_n         (rst_n),
    .read_pointer_gray     (rp),
    .write_pointer_bin     (wp),
    .sync_read_pointer     (sync_rp),
    .sync_read_pointer_bin (sync_bin),
    .read_advance          (adv),
    .advance_delta         (delta),
    .free_slots            (free_slots),
    .full                  (full),
    .gray_error            (gray_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: h[k] is the Gray input seen at the k-th edge after reset.
  int h [0:1023];
  int n = 0;
  bit ge_m = 1'b0;

  function automatic int hist(input int j);
    return (j < 1) ? 0 : h[j];
  endfunction

  // Binary value whose Gray encoding is g.
  function automatic int g2b(input int g);
    for (int b = 0; b < 16; b++) if ((b ^ (b >> 1)) == g) return b;
    return 0;
  endfunction

  always @(posedge clk) begin
    int cur, prev, occ, a, b, dl;
    if (!rst_n) begin
      n = 0;
      ge_m = 1'b0;
    end else begin
      if (n < 1023) n++;
      h[n] = int'(rp);
      a = hist(n - S);
      b = hist(n - S + 1);
      if ($countones(4'(a ^ b)) > 1) ge_m = 1'b1;
    end
    #1;
    cur  = g2b(hist(n - S));
    prev = g2b(hist(n - S - 1));
    dl   = (cur - prev) & 15;
    chk("m_sync_rp", int'(sync_rp), hist(n - S + 1));
    chk("m_sync_bin", int'(sync_bin), cur);
    chk("m_delta", int'(delta), dl);
    chk("m_advance", int'(adv), (dl != 0) ? 1 : 0);
    occ = (int'(wp) - cur) & 15;
    if (occ <= DEPTH) begin
      chk("m_free", int'(free_slots), DEPTH - occ);
      chk("m_full", int'(full), (occ == DEPTH) ? 1 : 0);
    end
`ifdef SYNC_GRAY_CHECK_EN
    chk("m_gray_error", int'(gray_error), int'(ge_m));
`else
    chk("m_gray_error", int'(gray_error), 0);
`endif
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  int ge_exp;

  initial begin
`ifdef SYNC_GRAY_CHECK_EN
    ge_exp = 1;
`else
    ge_exp = 0;
`endif
    rst_n = 1'b0;
    rp = 4'd0;
    wp = 4'd0;
    tick(2);

    // Reset state
    chk("rst_sync", int'(sync_rp), 0);
    chk("rst_bin", int'(sync_bin), 0);
    chk("rst_adv", int'(adv), 0);
    chk("rst_delta", int'(delta), 0);
    chk("rst_free", int'(free_slots), 8);
    chk("rst_full", int'(full), 0);
    chk("rst_gerr", int'(gray_error), 0);

    // Full with read pointer at 0
    wp = 4'b1000;
    #1;
    chk("full_wp8", int'(full), 1);
    chk("free_wp8", int'(free_slots), 0);
    wp = 4'd0;
    rst_n = 1'b1;

    // Single step latency
    rp = 4'b0001;
    tick(2);
    chk("lat_sync", int'(sync_rp), 1);
    tick(1);
    chk("lat_bin", int'(sync_bin), 1);
    chk("lat_adv", int'(adv), 1);
    chk("lat_delta", int'(delta), 1);
    tick(1);
    chk("lat_adv_off", int'(adv), 0);

    // Consecutive Gray steps then a multi-slot jump
    rp = 4'd0;
    wp = 4'b1000;
    pulse_reset();
    rp = 4'b0001; tick(1);
    rp = 4'b0011; tick(1);
    rp = 4'b0010; tick(1);
    chk("seq_bin1", int'(sync_bin), 1);
    chk("seq_adv1", int'(adv), 1);
    chk("seq_d1", int'(delta), 1);
    tick(1);
    chk("seq_bin2", int'(sync_bin), 2);
    chk("seq_d2", int'(delta), 1);
    tick(1);
    chk("seq_bin3", int'(sync_bin), 3);
    chk("seq_d3", int'(delta), 1);
    tick(1);
    chk("seq_adv_off", int'(adv), 0);
    tick(3);
    rp = 4'b0100;
    tick(2);
    chk("jump_sync", int'(sync_rp), 4);
    tick(1);
    chk("jump_bin", int'(sync_bin), 7);
    chk("jump_adv", int'(adv), 1);
    chk("jump_delta", int'(delta), 4);
    chk("jump_free", int'(free_slots), 7);

    // Wrap: MSB differs, low bits equal
    rp = 4'b1110;
    wp = 4'd0;
    pulse_reset();
    tick(3);
    chk("wrap_bin", int'(sync_bin), 11);
    chk("wrap_delta", int'(delta), 11);
    chk("wrap_free5", int'(free_slots), 3);
    wp = 4'b0011;
    #1;
    chk("wrap_full", int'(full), 1);
    chk("wrap_free0", int'(free_slots), 0);
    wp = 4'b0010;
    #1;
    chk("wrap_notfull", int'(full), 0);
    chk("wrap_free1", int'(free_slots), 1);

    // Gray violation, stickiness and clear
    rp = 4'd0;
    wp = 4'd0;
    pulse_reset();
    tick(2);
    rp = 4'b0011;
    tick(1);
    chk("gerr_edge1", int'(gray_error), 0);
    tick(1);
    chk("gerr_edge2", int'(gray_error), ge_exp);
    rp = 4'b0010;
    tick(4);
    chk("gerr_sticky", int'(gray_error), ge_exp);
    rst_n = 1'b0;
    #1;
    chk("gerr_clear", int'(gray_error), 0);
    tick(1);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle
    rp = 4'b0011;
    wp = 4'd5;
    tick(4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_sync", int'(sync_rp), 0);
    chk("arst_bin", int'(sync_bin), 0);
    chk("arst_adv", int'(adv), 0);
    chk("arst_delta", int'(delta), 0);
    chk("arst_gerr", int'(gray_error), 0);
    chk("arst_free", int'(free_slots), 3);
    chk("arst_full", int'(full), 0);
    rp = 4'b0110;
    wp = 4'd0;
    tick(1);
    #1;
    rst_n = 1'b1;
    tick(2);
    chk("rel_sync", int'(sync_rp), 6);
    tick(1);
    chk("rel_bin", int'(sync_bin), 4);
    chk("rel_adv", int'(adv), 1);
    chk("rel_delta", int'(delta), 4);
    tick(1);
    chk("rel_adv_off", int'(adv), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
